// File: rtl/indexed_regfile_mc_pkg.sv
// Shared definitions for the multi-channel indexed register file:
// index-width helper, read-channel state encoding and response record layout.
package indexed_regfile_mc_pkg;

  // Output stage of a read channel: EMPTY holds no response, FULL presents one.
  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  // Index width for a table of 'depth' entries; a 1-entry table still needs one bit.
  function automatic int idxw_f(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Response record is {err, data}: err sits one bit above the data word.
  function automatic int rsp_w_f(input int width);
    return width + 1;
  endfunction

  // INIT packing: entry k lives at INIT[k*WIDTH +: WIDTH], entry 0 in the LSBs.

endpackage

// File: rtl/indexed_regfile_mc_read_channel.sv
// One read channel: valid/ready request, table lookup with write-first bypass,
// out-of-range detection and a one-entry registered response stage.
module indexed_regfile_mc_read_channel
  import indexed_regfile_mc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int IDXW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH*DEPTH-1:0] mem_flat,
  input  logic                   wr_hit,
  input  logic [IDXW-1:0]        wr_index,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IDXW-1:0]        req_index,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err
);

  localparam int             RSPW    = rsp_w_f(WIDTH);
  // DEPTH may equal 2**IDXW, so compare with one extra bit.
  localparam logic [IDXW:0]  DEPTH_W = (IDXW+1)'(DEPTH);

  ch_state_e        state_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             in_range_s;
  logic [WIDTH-1:0] mem_word_s;
  logic [WIDTH-1:0] word_s;
  logic [RSPW-1:0]  rsp_d;
  logic             accept_s;

  // Lookup: one-hot mux over entries, bypass a same-cycle write, flag out-of-range.
  always_comb begin
    in_range_s = ({1'b0, req_index} < DEPTH_W);
    mem_word_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mem_word_s = mem_word_s |
                   (mem_flat[k*WIDTH +: WIDTH] & {WIDTH{req_index == IDXW'(k)}});
    end
    if (wr_hit && (wr_index == req_index)) begin
      word_s = wr_data;
    end else begin
      word_s = mem_word_s;
    end
    if (in_range_s) begin
      rsp_d = {1'b0, word_s};
    end else begin
      rsp_d = {1'b1, {WIDTH{1'b0}}};
    end
  end

  // A slot frees up in the same cycle the consumer takes the current response.
  assign req_ready = rst_n & ((state_q == CH_EMPTY) | rsp_ready);
  assign accept_s  = req_valid & req_ready;

  // Output stage FSM: capture on accept, drain on rsp_ready, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CH_EMPTY;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        CH_EMPTY: begin
          if (accept_s) begin
            state_q    <= CH_FULL;
            rsp_data_q <= rsp_d[WIDTH-1:0];
            rsp_err_q  <= rsp_d[RSPW-1];
          end
        end
        CH_FULL: begin
          if (accept_s) begin
            rsp_data_q <= rsp_d[WIDTH-1:0];
            rsp_err_q  <= rsp_d[RSPW-1];
          end else if (rsp_ready) begin
            state_q <= CH_EMPTY;
          end
        end
        default: begin
          state_q <= CH_EMPTY;
        end
      endcase
    end
  end

  assign rsp_valid = (state_q == CH_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: rtl/indexed_regfile_mc.sv
// Multi-channel indexed register file: INIT-loaded storage, one write port with
// out-of-range flag, NREAD independent registered read channels.
module indexed_regfile_mc
  import indexed_regfile_mc_pkg::*;
#(
  parameter int                     WIDTH = 4,
  parameter int                     DEPTH = 4,
  parameter int                     NREAD = 2,
  parameter logic [WIDTH*DEPTH-1:0] INIT  = {4'd4, 4'd3, 4'd2, 4'd1},
  localparam int                    IDXW  = idxw_f(DEPTH)
) (
  input  logic [1:0]             clock_reset,
  input  logic                   wr_en,
  input  logic [IDXW-1:0]        wr_index,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_err,
  input  logic [NREAD-1:0]       rd_req_valid,
  output logic [NREAD-1:0]       rd_req_ready,
  input  logic [NREAD*IDXW-1:0]  rd_req_index,
  output logic [NREAD-1:0]       rd_rsp_valid,
  input  logic [NREAD-1:0]       rd_rsp_ready,
  output logic [NREAD*WIDTH-1:0] rd_rsp_data,
  output logic [NREAD-1:0]       rd_rsp_err
);

  localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);

  logic                   clk;
  logic                   rst_n;
  logic [WIDTH*DEPTH-1:0] mem_q;
  logic [WIDTH*DEPTH-1:0] mem_d;
  logic                   wr_err_q;
  logic                   wr_err_d;
  logic                   wr_in_range_s;
  logic                   wr_hit_s;

  assign clk   = clock_reset[0];
  assign rst_n = clock_reset[1];

  // Write decode: in-range writes update one entry, out-of-range writes only raise wr_err.
  always_comb begin
    wr_in_range_s = ({1'b0, wr_index} < DEPTH_W);
    wr_hit_s      = wr_en & wr_in_range_s;
    wr_err_d      = wr_en & ~wr_in_range_s;
    mem_d         = mem_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (wr_hit_s && (wr_index == IDXW'(k))) begin
        mem_d[k*WIDTH +: WIDTH] = wr_data;
      end else begin
        mem_d[k*WIDTH +: WIDTH] = mem_q[k*WIDTH +: WIDTH];
      end
    end
  end

  // Storage and write-error flag; reset restores the INIT table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= INIT;
      wr_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err = wr_err_q;

  for (genvar c = 0; c < NREAD; c++) begin : g_rd
    indexed_regfile_mc_read_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IDXW  (IDXW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_flat  (mem_q),
      .wr_hit    (wr_hit_s),
      .wr_index  (wr_index),
      .wr_data   (wr_data),
      .req_valid (rd_req_valid[c]),
      .req_ready (rd_req_ready[c]),
      .req_index (rd_req_index[c*IDXW +: IDXW]),
      .rsp_valid (rd_rsp_valid[c]),
      .rsp_ready (rd_rsp_ready[c]),
      .rsp_data  (rd_rsp_data[c*WIDTH +: WIDTH]),
      .rsp_err   (rd_rsp_err[c])
    );
  end

endmodule

// File: tb/tb_indexed_regfile_mc.sv
// Scoreboard bench: stimulus pushes hand-computed responses, a negedge monitor
// pops and compares on each response handshake and checks 1-cycle latency.
module tb_indexed_regfile_mc;

  typedef struct {
    int         acc;
    logic [3:0] data;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [1:0] cr;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // DUT A: default 4x4, two channels
  logic       a_wr_en, a_wr_err;
  logic [1:0] a_wr_index;
  logic [3:0] a_wr_data;
  logic [1:0] a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [3:0] a_req_index;
  logic [7:0] a_rsp_data;
  // DUT B: DEPTH=5 (IDXW=3), one channel
  logic       b_wr_en, b_wr_err;
  logic [2:0] b_wr_index;
  logic [3:0] b_wr_data;
  logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [2:0] b_req_index;
  logic [3:0] b_rsp_data;

  assign cr = {rst_n, clk};

  indexed_regfile_mc u_a (
    .clock_reset (cr), .wr_en (a_wr_en), .wr_index (a_wr_index), .wr_data (a_wr_data),
    .wr_err (a_wr_err), .rd_req_valid (a_req_valid), .rd_req_ready (a_req_ready),
    .rd_req_index (a_req_index), .rd_rsp_valid (a_rsp_valid), .rd_rsp_ready (a_rsp_ready),
    .rd_rsp_data (a_rsp_data), .rd_rsp_err (a_rsp_err)
  );

  indexed_regfile_mc #(.WIDTH(4), .DEPTH(5), .NREAD(1), .INIT(20'h54321)) u_b (
    .clock_reset (cr), .wr_en (b_wr_en), .wr_index (b_wr_index), .wr_data (b_wr_data),
    .wr_err (b_wr_err), .rd_req_valid (b_req_valid), .rd_req_ready (b_req_ready),
    .rd_req_index (b_req_index), .rd_rsp_valid (b_rsp_valid), .rd_rsp_ready (b_rsp_ready),
    .rd_rsp_data (b_rsp_data), .rd_rsp_err (b_rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [3:0] d, input logic e);
    exp_t x;
    x.acc = cyc + 1;
    x.data = d;
    x.err = e;
    case (id)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic mon(input int id, input logic v, input logic r, input logic [3:0] d, input logic e);
    exp_t x;
    int   n;
    n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (n > 0) begin
      case (id)
        0: x = q0[0];
        1: x = q1[0];
        default: x = q2[0];
      endcase
      if (x.acc == cyc) chk($sformatf("latency_ch%0d", id), {31'd0, v}, 32'd1);
    end
    if (v && r) begin
      if (n == 0) begin
        chk($sformatf("spurious_rsp_ch%0d", id), n, 32'd1);
      end else begin
        case (id)
          0: x = q0.pop_front();
          1: x = q1.pop_front();
          default: x = q2.pop_front();
        endcase
        chk($sformatf("rsp_data_ch%0d", id), {28'd0, d}, {28'd0, x.data});
        chk($sformatf("rsp_err_ch%0d", id), {31'd0, e}, {31'd0, x.err});
      end
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, a_rsp_valid[0], a_rsp_ready[0], a_rsp_data[3:0], a_rsp_err[0]);
    mon(1, a_rsp_valid[1], a_rsp_ready[1], a_rsp_data[7:4], a_rsp_err[1]);
    mon(2, b_rsp_valid, b_rsp_ready, b_rsp_data, b_rsp_err);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input int ch, input logic [1:0] idx, input logic [3:0] d, input logic e);
    a_req_valid[ch] = 1'b1;
    a_req_index[ch*2 +: 2] = idx;
    push(ch, d, e);
  endtask

  task automatic rd_b(input logic [2:0] idx, input logic [3:0] d, input logic e);
    b_req_valid = 1'b1;
    b_req_index = idx;
    push(2, d, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    a_req_valid = 2'b00;
    b_req_valid = 1'b0;
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    #1;
    chk("rst_a_req_ready", {30'd0, a_req_ready}, 32'd0);
    chk("rst_a_rsp_valid", {30'd0, a_rsp_valid}, 32'd0);
    chk("rst_a_rsp_data", {24'd0, a_rsp_data}, 32'd0);
    chk("rst_a_rsp_err", {30'd0, a_rsp_err}, 32'd0);
    chk("rst_a_wr_err", {31'd0, a_wr_err}, 32'd0);
    chk("rst_b_req_ready", {31'd0, b_req_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    a_wr_en = 1'b0; a_wr_index = 2'd0; a_wr_data = 4'd0;
    a_req_valid = 2'b00; a_req_index = 4'd0; a_rsp_ready = 2'b11;
    b_wr_en = 1'b0; b_wr_index = 3'd0; b_wr_data = 4'd0;
    b_req_valid = 1'b0; b_req_index = 3'd0; b_rsp_ready = 1'b1;
    #1;
    do_reset();
    #1;
    chk("idle_req_ready", {30'd0, a_req_ready}, 32'd3);

    // 1: INIT read
    rd_a(0, 2'd3, 4'h4, 1'b0);
    step();
    a_req_valid = 2'b00;
    step();

    // 2: write then two channels in one cycle
    a_wr_en = 1'b1; a_wr_index = 2'd1; a_wr_data = 4'hA;
    step();
    a_wr_en = 1'b0;
    rd_a(0, 2'd1, 4'hA, 1'b0);
    rd_a(1, 2'd0, 4'h1, 1'b0);
    step();
    a_req_valid = 2'b00;
    step();

    // 3: write-first bypass, then persistence
    a_wr_en = 1'b1; a_wr_index = 2'd2; a_wr_data = 4'h7;
    rd_a(1, 2'd2, 4'h7, 1'b0);
    step();
    a_wr_en = 1'b0;
    a_req_valid = 2'b00;
    rd_a(1, 2'd2, 4'h7, 1'b0);
    rd_a(0, 2'd2, 4'h7, 1'b0);
    step();
    a_req_valid = 2'b00;
    step();

    // 4: backpressure on ch0, then a full-rate stream from fresh INIT
    do_reset();
    step();
    a_rsp_ready[0] = 1'b0;
    rd_a(0, 2'd0, 4'h1, 1'b0);
    step();
    a_req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, a_rsp_valid[0]}, 32'd1);
      chk("stall_data", {28'd0, a_rsp_data[3:0]}, 32'd1);
      chk("stall_req_ready", {31'd0, a_req_ready[0]}, 32'd0);
      step();
    end
    a_rsp_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_a(0, 2'(i), 4'(i + 1), 1'b0);
      if (i == 0) begin
        #1;
        chk("release_req_ready", {31'd0, a_req_ready[0]}, 32'd1);
      end
      step();
    end
    a_req_valid = 2'b00;
    step();

    // 5: DEPTH=5 boundaries and out-of-range write
    rd_b(3'd6, 4'h0, 1'b1);
    step();
    rd_b(3'd5, 4'h0, 1'b1);
    step();
    rd_b(3'd4, 4'h5, 1'b0);
    step();
    b_req_valid = 1'b0;
    b_wr_en = 1'b1; b_wr_index = 3'd7; b_wr_data = 4'hF;
    step();
    chk("wr_err_set", {31'd0, b_wr_err}, 32'd1);
    b_wr_en = 1'b0;
    step();
    chk("wr_err_clear", {31'd0, b_wr_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd_b(3'(i), 4'(i + 1), 1'b0);
      step();
    end
    b_req_valid = 1'b0;
    step();

    // 6: reset mid-transaction restores INIT and drops the pending response
    a_wr_en = 1'b1; a_wr_index = 2'd0; a_wr_data = 4'hF;
    step();
    a_wr_en = 1'b0;
    rd_a(0, 2'd0, 4'hF, 1'b0);
    a_rsp_ready[0] = 1'b0;
    step();
    a_req_valid = 2'b00;
    chk("pre_rst_data", {28'd0, a_rsp_data[3:0]}, 32'hF);
    #2;
    do_reset();
    a_rsp_ready[0] = 1'b1;
    step();
    rd_a(0, 2'd0, 4'h1, 1'b0);
    step();
    a_req_valid = 2'b00;
    step();
    step();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
